// File: rtl/sram_bus_arbiter.sv
// Purpose     : shares one SRAM-like master bus between instruction fetch and data access.
// Latency     : request to addr_ok 0 cycles from IDLE; one bubble cycle after each data_ok.
// Backpressure: a request is held in REQ until m_addr_ok; one transaction outstanding at a time.
//
// Ports:
//   clk, resetn                - rising-edge clock, async active-low reset
//   inst_* (req/addr in; addr_ok/data_ok/rdata out) - instruction read port
//   data_* (req/wr/size/addr/wdata in; addr_ok/data_ok/rdata out) - data port
//   m_* (req/wr/size/addr/wdata out; addr_ok/data_ok/rdata in) - shared master bus
module sram_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // master bus
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic {INST = 1'b0, DATA = 1'b1} owner_t;

  localparam logic [3:0] StreakMax = 4'(STREAK_MAX);

  state_t     state, stateNext;
  owner_t     owner, ownerNext;
  logic [3:0] streak, streakNext;

  logic grantData;  // data wins the IDLE arbitration
  logic anyReq;
  logic selData;    // master fields and handshakes steered to the data port
  logic accept;     // master accepted the request this cycle

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      owner  <= INST;
      streak <= 4'd0;
    end else begin
      state  <= stateNext;
      owner  <= ownerNext;
      streak <= streakNext;
    end
  end

  always_comb begin
    // Data has priority unless inst is waiting and data already had its full streak.
    grantData    = data_req && !(inst_req && (streak == StreakMax));
    anyReq       = inst_req | data_req;

    stateNext    = state;
    ownerNext    = owner;
    streakNext   = streak;
    selData      = (owner == DATA);
    accept       = 1'b0;
    m_req        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    case (state)
      IDLE: begin
        // Winner is steered straight through so a ready slave accepts in this cycle.
        selData = grantData;
        m_req   = anyReq;
        if (anyReq) begin
          ownerNext = grantData ? DATA : INST;
          if (m_addr_ok) begin
            accept    = 1'b1;
            stateNext = WAIT;
          end else begin
            stateNext = REQ;
          end
        end
      end
      REQ: begin
        // Owner is locked; the other requester cannot preempt a stalled request.
        m_req = 1'b1;
        if (m_addr_ok) begin
          accept    = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (m_data_ok) begin
          stateNext = IDLE;
          if (owner == DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = m_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = m_rdata;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (accept) begin
      if (selData) begin
        data_addr_ok = 1'b1;
        // Only a contested data grant extends the streak; saturate at the limit.
        if (inst_req) begin
          streakNext = (streak >= StreakMax) ? StreakMax : 4'(streak + 4'd1);
        end else begin
          streakNext = 4'd0;
        end
      end else begin
        inst_addr_ok = 1'b1;
        streakNext   = 4'd0;
      end
    end

    // Instruction fetches are always word reads.
    m_wr    = selData ? data_wr    : 1'b0;
    m_size  = selData ? data_size  : 2'd2;
    m_addr  = selData ? data_addr  : inst_addr;
    m_wdata = selData ? data_wdata : '0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Purpose     : self-checking bench for sram_bus_arbiter with a reactive slave and response scoreboard.
// Latency     : slave accepts combinationally when ready, responds rspDelay cycles later.
// Backpressure: slvRdy low stalls the master bus to exercise the REQ state.
module tb_sram_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]    data_size = 2'd2;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          m_req, m_wr;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_addr_ok, m_data_ok;
  logic [DW-1:0] m_rdata;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Slave memory model: fixed read pattern, writes return zero.
  function automatic logic [31:0] rdataOf(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_0001;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Reactive slave
  logic          slvRdy = 1'b1;
  logic          extraDataOk = 1'b0;
  int            rspDelay = 1;
  int            pendCnt = 0;
  logic [DW-1:0] pendRdata = '0;

  assign m_addr_ok = m_req & slvRdy;
  assign m_data_ok = (pendCnt == 1) | extraDataOk;
  assign m_rdata   = pendRdata;

  always @(posedge clk) begin
    if (m_req && m_addr_ok) begin
      pendCnt   <= rspDelay;
      pendRdata <= m_wr ? '0 : rdataOf(m_addr);
    end else if (pendCnt > 0) begin
      pendCnt <= pendCnt - 1;
    end
  end

  // Scoreboard: expected read data per requester, plus grant log {isData, streak at grant}.
  logic [DW-1:0] instQ[$];
  logic [DW-1:0] dataQ[$];
  logic [4:0]    grantLog[$];

  always @(negedge clk) begin
    if (inst_addr_ok) grantLog.push_back({1'b0, dut.streak});
    if (data_addr_ok) grantLog.push_back({1'b1, dut.streak});
    if (inst_data_ok) begin
      if (instQ.size() == 0) chk("inst_rsp_unexpected", 32'd1, 32'd0);
      else chk("inst_rdata", inst_rdata, instQ.pop_front());
    end
    if (data_data_ok) begin
      if (dataQ.size() == 0) chk("data_rsp_unexpected", 32'd1, 32'd0);
      else chk("data_rdata", data_rdata, dataQ.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the port's addr_ok, then drop its request after the edge.
  task automatic waitAddrOk(input bit isData, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (isData ? data_addr_ok : inst_addr_ok) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    tick();
    if (isData) data_req = 1'b0;
    else inst_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instQ.size() == 0 && dataQ.size() == 0 && dut.state == 2'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic dataReqSeq(input int n);
    for (int k = 0; k < n; k++) begin
      data_req  = 1'b1;
      data_wr   = 1'b0;
      data_size = 2'd2;
      data_addr = 32'h2000 + 32'(4 * k);
      dataQ.push_back(rdataOf(data_addr));
      waitAddrOk(1'b1, "starve_data_ack");
    end
  endtask

  task automatic instReqOne();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0100;
    instQ.push_back(rdataOf(inst_addr));
    waitAddrOk(1'b0, "starve_inst_ack");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  logic [4:0] expLog[6];

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_owner", 32'(dut.owner), 32'd0);
    chk("rst_streak", 32'(dut.streak), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Inst only: accepted same cycle, data one cycle later
    slvRdy = 1'b1; rspDelay = 1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    instQ.push_back(32'h3C1D_0001);
    @(negedge clk);
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("t1_m_addr", m_addr, 32'hBFC0_0000);
    chk("t1_m_size", 32'(m_size), 32'd2);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t1_inst_rdata_now", inst_rdata, 32'h3C1D_0001);
    chk("t1_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("t1_m_req_wait", 32'(m_req), 32'd0);
    drain("t1_drain");

    // Simultaneous requests with streak 0: data wins
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    instQ.push_back(rdataOf(32'hBFC0_0004));
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h1000; data_wdata = 32'hDEAD_BEEF;
    dataQ.push_back(32'h0);
    @(negedge clk);
    chk("t2_m_wr", 32'(m_wr), 32'd1);
    chk("t2_m_addr", m_addr, 32'h1000);
    chk("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("t2_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    @(negedge clk);
    chk("t2_streak", 32'(dut.streak), 32'd1);
    waitAddrOk(1'b0, "t2_inst_ack");
    drain("t2_drain");
    chk("t2_streak_after_inst", 32'(dut.streak), 32'd0);

    // Starvation guard: 4 contested data grants, then inst, then remaining data
    grantLog.delete();
    fork
      dataReqSeq(5);
      instReqOne();
    join
    drain("t3_drain");
    expLog = '{5'b1_0000, 5'b1_0001, 5'b1_0010, 5'b1_0011, 5'b0_0100, 5'b1_0000};
    chk("t3_grant_count", 32'(grantLog.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grantLog.size()) chk($sformatf("t3_grant%0d", i), 32'(grantLog[i]), 32'(expLog[i]));
      else chk($sformatf("t3_grant%0d_missing", i), 32'd0, 32'(expLog[i]));
    end
    chk("t3_streak_end", 32'(dut.streak), 32'd0);

    // Slave stall: request locked in REQ, inst cannot preempt
    slvRdy = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h3000;
    dataQ.push_back(rdataOf(32'h3000));
    @(negedge clk);
    chk("t4_m_req", 32'(m_req), 32'd1);
    chk("t4_m_addr0", m_addr, 32'h3000);
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    instQ.push_back(rdataOf(32'hBFC0_0200));
    @(negedge clk);
    chk("t4_state_req", 32'(dut.state), 32'd1);
    chk("t4_m_addr1", m_addr, 32'h3000);
    chk("t4_m_size", 32'(m_size), 32'd1);
    chk("t4_owner", 32'(dut.owner), 32'd1);
    chk("t4_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_m_addr2", m_addr, 32'h3000);
    tick();
    slvRdy = 1'b1;
    waitAddrOk(1'b1, "t4_data_ack");
    waitAddrOk(1'b0, "t4_inst_ack");
    drain("t4_drain");

    // m_data_ok in IDLE with nothing outstanding
    extraDataOk = 1'b1;
    @(negedge clk);
    chk("t5_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t5_data_data_ok", 32'(data_data_ok), 32'd0);
    tick();
    extraDataOk = 1'b0;

    // Reset while waiting for a response; late m_data_ok is ignored
    rspDelay = 3;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
    @(negedge clk);
    chk("t6_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("t6_state_wait", 32'(dut.state), 32'd2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_state_idle", 32'(dut.state), 32'd0);
    tick();
    @(negedge clk);
    chk("t6_late_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t6_late_data_data_ok", 32'(data_data_ok), 32'd0);
    tick();
    rspDelay = 1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    instQ.push_back(32'h3C1D_0001);
    waitAddrOk(1'b0, "t6_inst_ack");
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like master bus between the CPU's instruction-fetch port and data-access port, so the core can run on a single unified memory interface.
- Sits between the pipeline (IF fetch, ME load/store) and the memory/bridge.
- Arbitrates with data priority plus an anti-starvation streak counter.
- Sequences exactly one outstanding transaction at a time through a 3-state FSM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STREAK_MAX, 4, consecutive contested data grants allowed before a pending inst request must win (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  instruction read request; held stable until inst_addr_ok.
- inst_addr  in  ADDR_W  instruction address.
- inst_addr_ok  out  1  inst request accepted this cycle.
- inst_data_ok  out  1  inst read data valid this cycle.
- inst_rdata  out  DATA_W  inst read data.
- data_req  in  1  data request; held stable until data_addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response (read data or write ack) this cycle.
- data_rdata  out  DATA_W  data read data.
- m_req  out  1  master request.
- m_wr  out  1  master write.
- m_size  out  2  master size.
- m_addr  out  ADDR_W  master address.
- m_wdata  out  DATA_W  master write data.
- m_addr_ok  in  1  slave accepted request.
- m_data_ok  in  1  slave response valid.
- m_rdata  in  DATA_W  slave read data.

Behaviour:
- Registered state:
  - state ∈ {IDLE, REQ, WAIT}.
  - owner ∈ {INST, DATA}.
  - streak, 4-bit counter.
- Reset (async, resetn=0): state=IDLE, owner=INST, streak=0.
  - All requester handshake outputs are 0.
  - m_req=0.
  - Data outputs are don't-care but driven 0.
- Grant function, evaluated in IDLE only:
  - Data wins if data_req and not (inst_req and streak==STREAK_MAX).
  - Otherwise inst wins if inst_req.
- IDLE:
  - m_req = inst_req | data_req. m_* fields are muxed combinationally from the winner; inst uses wr=0, size=2, wdata=0.
  - If m_addr_ok: assert the winner's addr_ok in the same cycle, latch owner, go to WAIT.
  - Else if any req: latch owner, go to REQ.
- REQ:
  - m_req=1 with the latched owner's fields, which are locked; the other requester cannot preempt.
  - On m_addr_ok: assert the owner's addr_ok, go to WAIT.
- WAIT:
  - m_req=0.
  - On m_data_ok: pulse the owner's data_ok for 1 cycle, pass m_rdata to the owner's rdata, go to IDLE.
  - A new grant is possible in the next cycle only, giving a 1-cycle bubble between transactions.
- m_addr_ok while m_req=0 is ignored. m_data_ok in IDLE or REQ is ignored.
- Streak counter, updated on acceptance (the cycle addr_ok is asserted to a requester):
  - Data accepted while inst_req=1: streak ← min(streak+1, STREAK_MAX).
  - Inst accepted: streak ← 0.
  - Data accepted while inst_req=0: streak ← 0.
  - No acceptance: unchanged.
- Minimum latency:
  - Request to addr_ok: 0 cycles (combinational pass-through in IDLE).
  - addr_ok to data_ok: slave latency, at least 1 cycle.
- Reset mid-transaction: the outstanding transaction is abandoned. A later m_data_ok arrives in IDLE and is ignored.
- Requester outputs for the non-owner stay 0 at all times.

Test Plan:
- Inst only: inst_req=1, addr=0xBFC00000, slave addr_ok same cycle, data_ok 1 cycle later with 0x3C1D0001 -> inst_addr_ok in cycle 0, inst_data_ok + inst_rdata=0x3C1D0001 in cycle 1, data_* handshakes stay 0.
- Simultaneous requests, streak=0: inst_req and data_req (wr=1, size=2, addr=0x1000, wdata=0xDEADBEEF) in IDLE -> m_wr=1, m_addr=0x1000, m_wdata=0xDEADBEEF, data_addr_ok=1, then streak=1.
- Starvation guard, STREAK_MAX=4: both requesters held continuously -> 4 data grants, then inst grant, with streak returning to 0.
- Slave stall: m_addr_ok held 0 for 3 cycles after data_req -> state=REQ, m_addr stable. Raising inst_req mid-stall does not change m_addr. Owner stays DATA.
- Response boundary: m_data_ok asserted in IDLE with no outstanding request -> no data_ok pulse on either requester.
- Reset mid-operation: resetn low in WAIT, released, then m_data_ok=1 -> ignored; next inst_req is serviced normally.
